// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM states, byte framing constants and address decode helper.
package i2c_pkg;

  localparam int I2C_BYTE_BITS = 8;
  localparam int RW_BIT        = 0;
  localparam logic ACK         = 1'b0;
  localparam logic NACK        = 1'b1;

  localparam logic [3:0] BYTE_DONE = 4'(I2C_BYTE_BITS);
  localparam logic [3:0] LAST_TX   = 4'(I2C_BYTE_BITS - 1);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_MACK      = 4'd8
  } i2c_state_e;

  // General call (address 0) never matches, even if the own address were configured to 0.
  function automatic logic addr_match(input logic [7:0] hdr, input logic [6:0] own);
    return (hdr[7:1] == own) && (hdr[7:1] != 7'd0);
  endfunction

endpackage

// File: rtl/i2c_slave_regs_if.sv
// Register-file side bus of the I2C responder: pointer, write strobe/data, read request/data.
interface i2c_slave_regs_if;

  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_wr,
    output reg_rd,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_wr,
    input  reg_rd,
    output reg_rdata
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers on SCL/SDA plus one history flop; emits registered
// single-cycle scl_rise/scl_fall/start/stop events (3 cycles pin-to-event).
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_hist_q, sda_hist_q;
  logic [1:0] fill_q, fill_d;
  logic       armed;
  logic       scl_rise_q, scl_fall_q, start_q, stop_q;
  logic       scl_rise_d, scl_fall_d, start_d, stop_d;

  // Events stay masked until the history flop holds a real pin sample, so lines
  // that are already low at power-up cannot fake an edge.
  always_comb begin
    armed      = (fill_q == 2'd3);
    fill_d     = armed ? fill_q : (fill_q + 2'd1);
    scl_rise_d = armed &  scl_sync_q[1] & ~scl_hist_q;
    scl_fall_d = armed & ~scl_sync_q[1] &  scl_hist_q;
    start_d    = armed &  scl_sync_q[1] & scl_hist_q &  sda_hist_q & ~sda_sync_q[1];
    stop_d     = armed &  scl_sync_q[1] & scl_hist_q & ~sda_hist_q &  sda_sync_q[1];
  end

  // Synchronizer, history and event registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      fill_q     <= 2'd0;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
      fill_q     <= fill_d;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign sda_o      = sda_hist_q;
  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C responder with an 8-bit auto-incrementing register pointer; SDA is
// open-drain (0 or z), SCL is never driven.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             scl,
  inout  wire              sda,
  output logic             busy,
  i2c_slave_regs_if.master regs
);

  logic       scl_rise_ev, scl_fall_ev, start_ev, stop_ev, sda_smp;

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_wr_q, reg_wr_d;
  logic       reg_rd_q, reg_rd_d;
  logic       rd_pend_q, rd_pend_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;

  i2c_line_sync u_sync (
    .clk        (sys_clk),
    .rst_n      (rst_n),
    .scl_i      (scl),
    .sda_i      (sda),
    .sda_o      (sda_smp),
    .scl_rise_o (scl_rise_ev),
    .scl_fall_o (scl_fall_ev),
    .start_o    (start_ev),
    .stop_o     (stop_ev)
  );

  // Next-state and output decode; START/STOP override any byte in flight.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    reg_addr_d  = reg_wr_q ? (reg_addr_q + 8'd1) : reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    rd_pend_d   = reg_rd_q;
    sda_oe_d    = sda_oe_q;

    if (start_ev) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      shift_d   = 8'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_ev) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 4'd0;
        end
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise_ev && (bit_cnt_q != BYTE_DONE)) begin
            shift_d   = {shift_q[6:0], sda_smp};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_ev && (bit_cnt_q == BYTE_DONE)) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b1;
            case (state_q)
              ST_ADDR: begin
                if (addr_match(shift_q, SLAVE_ADDR)) begin
                  state_d = ST_ADDR_ACK;
                  rw_d    = shift_q[RW_BIT];
                end else begin
                  state_d  = ST_IDLE;
                  sda_oe_d = 1'b0;
                end
              end
              ST_PTR: begin
                reg_addr_d = shift_q;
                state_d    = ST_PTR_ACK;
              end
              ST_WDATA: begin
                reg_wdata_d = shift_q;
                reg_wr_d    = 1'b1;
                state_d     = ST_WDATA_ACK;
              end
              default: begin
                state_d  = ST_IDLE;
                sda_oe_d = 1'b0;
              end
            endcase
          end else begin
            state_d = state_q;
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall_ev) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            case (state_q)
              ST_ADDR_ACK: begin
                if (rw_q) begin
                  state_d  = ST_RDATA;
                  reg_rd_d = 1'b1;
                end else begin
                  state_d = ST_PTR;
                end
              end
              ST_PTR_ACK, ST_WDATA_ACK: state_d = ST_WDATA;
              default:                  state_d = ST_IDLE;
            endcase
          end else begin
            state_d = state_q;
          end
        end
        // Read data lands two cycles after the request; each later SCL fall shifts one bit out.
        ST_RDATA: begin
          if (rd_pend_q) begin
            shift_d  = regs.reg_rdata;
            sda_oe_d = ~regs.reg_rdata[7];
          end else if (scl_fall_ev) begin
            if (bit_cnt_q == LAST_TX) begin
              state_d   = ST_MACK;
              bit_cnt_d = 4'd0;
              sda_oe_d  = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_MACK: begin
          if (scl_rise_ev) begin
            if (sda_smp == NACK) begin
              state_d = ST_IDLE;
            end else begin
              bit_cnt_d = 4'd1;
            end
          end else if (scl_fall_ev && (bit_cnt_q == 4'd1)) begin
            reg_rd_d   = 1'b1;
            reg_addr_d = reg_addr_q + 8'd1;
            bit_cnt_d  = 4'd0;
            state_d    = ST_RDATA;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          bit_cnt_d = 4'd0;
          sda_oe_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE) && (state_d != ST_ADDR);
  end

  // State and output registers; reset releases SDA on the same edge.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      rw_q        <= 1'b0;
      reg_addr_q  <= 8'd0;
      reg_wdata_q <= 8'd0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      rd_pend_q   <= rd_pend_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
    end
  end

  assign sda            = sda_oe_q ? 1'b0 : 1'bz;
  assign busy           = busy_q;
  assign regs.reg_addr  = reg_addr_q;
  assign regs.reg_wdata = reg_wdata_q;
  assign regs.reg_wr    = reg_wr_q;
  assign regs.reg_rd    = reg_rd_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-level I2C master at sys_clk/SCL = 20, memory model
// on the register bus, and a scoreboard of expected reg_wr/reg_rd strobes.
module tb_i2c_slave_regs;

  logic clk = 1'b0;
  logic rst_n;
  logic m_scl;
  logic m_oe;
  logic busy;
  wire  sda_w;

  always #5 clk = ~clk;

  pullup (sda_w);
  assign sda_w = m_oe ? 1'b0 : 1'bz;

  i2c_slave_regs_if regs();

  i2c_slave_regs #(.SLAVE_ADDR(7'h50)) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .scl     (m_scl),
    .sda     (sda_w),
    .busy    (busy),
    .regs    (regs)
  );

  typedef struct {
    bit         is_wr;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [256];
  int         checks = 0;
  int         failures = 0;
  logic       slave_drove = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Register file model: registered read, so rdata is valid the cycle after reg_rd.
  always @(posedge clk) begin
    if (regs.reg_wr) mem[regs.reg_addr] <= regs.reg_wdata;
    if (regs.reg_rd) regs.reg_rdata <= mem[regs.reg_addr];
  end

  // Monitor: pop one expectation per strobe; also note any slave-driven low on SDA.
  always @(negedge clk) begin
    if (!m_oe && (sda_w == 1'b0)) slave_drove = 1'b1;
    if (rst_n && (regs.reg_wr || regs.reg_rd)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("strobe_kind", regs.reg_wr, e.is_wr);
        chk("strobe_addr", regs.reg_addr, e.addr);
        if (e.is_wr) chk("wr_data", regs.reg_wdata, e.data);
      end
    end
  end

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.is_wr = 1'b1; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [7:0] a);
    exp_t e;
    e.is_wr = 1'b0; e.addr = a; e.data = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_oe = 1'b0;
    tick(8);
    m_scl = 1'b1;
    tick(5);
    m_oe = 1'b1;
    tick(5);
    m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(5);
    m_oe = 1'b1;
    tick(5);
    m_scl = 1'b1;
    tick(5);
    m_oe = 1'b0;
    tick(10);
  endtask

  task automatic bit_out(input logic b);
    tick(5);
    m_oe = ~b;
    tick(5);
    m_scl = 1'b1;
    tick(10);
    m_scl = 1'b0;
  endtask

  task automatic byte_out(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    tick(5);
    m_oe = 1'b0;
    tick(5);
    m_scl = 1'b1;
    tick(5);
    ack = sda_w;
    tick(5);
    m_scl = 1'b0;
  endtask

  task automatic byte_in(input logic mack, output logic [7:0] b);
    m_oe = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      tick(10);
      m_scl = 1'b1;
      tick(5);
      b[i] = sda_w;
      tick(5);
      m_scl = 1'b0;
    end
    tick(5);
    m_oe = ~mack;
    tick(5);
    m_scl = 1'b1;
    tick(10);
    m_scl = 1'b0;
    tick(3);
    m_oe = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic exp_ack, input string nm);
    logic a;
    byte_out(b, a);
    chk(nm, a, exp_ack);
  endtask

  task automatic recv(input logic mack, input logic [7:0] exp, input string nm);
    logic [7:0] d;
    byte_in(mack, d);
    chk(nm, d, exp);
  endtask

  initial begin
    m_scl = 1'b1;
    m_oe  = 1'b0;
    rst_n = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(5);
    chk("rst_addr", regs.reg_addr, 8'h00);
    chk("rst_wdata", regs.reg_wdata, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sda", sda_w, 1'b1);

    // Write with auto-increment
    push_wr(8'h10, 8'h5A);
    push_wr(8'h11, 8'hC3);
    i2c_start();
    send(8'hA0, 1'b0, "w_addr_ack");
    chk("w_busy", busy, 1'b1);
    send(8'h10, 1'b0, "w_ptr_ack");
    send(8'h5A, 1'b0, "w_d0_ack");
    send(8'hC3, 1'b0, "w_d1_ack");
    i2c_stop();
    chk("w_ptr_after", regs.reg_addr, 8'h12);
    chk("w_busy_after_stop", busy, 1'b0);

    // Random read through repeated START
    push_wr(8'h20, 8'h3C);
    push_wr(8'h21, 8'h7E);
    i2c_start();
    send(8'hA0, 1'b0, "pre_addr_ack");
    send(8'h20, 1'b0, "pre_ptr_ack");
    send(8'h3C, 1'b0, "pre_d0_ack");
    send(8'h7E, 1'b0, "pre_d1_ack");
    i2c_stop();
    push_rd(8'h20);
    push_rd(8'h21);
    i2c_start();
    send(8'hA0, 1'b0, "r_addr_ack");
    send(8'h20, 1'b0, "r_ptr_ack");
    i2c_start();
    send(8'hA1, 1'b0, "r_addr_rd_ack");
    recv(1'b0, 8'h3C, "r_byte0");
    recv(1'b1, 8'h7E, "r_byte1");
    chk("r_idle_after_nack", busy, 1'b0);
    chk("r_ptr_after", regs.reg_addr, 8'h21);
    i2c_stop();

    // Address mismatch: slave must stay silent
    slave_drove = 1'b0;
    i2c_start();
    send(8'hA2, 1'b1, "mm_addr_nack");
    send(8'h11, 1'b1, "mm_d0_nack");
    send(8'h22, 1'b1, "mm_d1_nack");
    chk("mm_busy", busy, 1'b0);
    i2c_stop();
    chk("mm_sda_never_driven", slave_drove, 1'b0);

    // Pointer wrap
    push_wr(8'hFF, 8'h01);
    push_wr(8'h00, 8'h02);
    i2c_start();
    send(8'hA0, 1'b0, "wrap_addr_ack");
    send(8'hFF, 1'b0, "wrap_ptr_ack");
    send(8'h01, 1'b0, "wrap_d0_ack");
    send(8'h02, 1'b0, "wrap_d1_ack");
    i2c_stop();
    chk("wrap_ptr_after", regs.reg_addr, 8'h01);

    // STOP in the middle of a data byte: no write
    i2c_start();
    send(8'hA0, 1'b0, "ab_addr_ack");
    send(8'h30, 1'b0, "ab_ptr_ack");
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    i2c_stop();
    chk("ab_wdata_kept", regs.reg_wdata, 8'h02);
    chk("ab_busy", busy, 1'b0);

    // Reset while the slave drives a 0 data bit
    push_wr(8'h40, 8'h12);
    i2c_start();
    send(8'hA0, 1'b0, "ab2_addr_ack");
    send(8'h40, 1'b0, "ab2_ptr_ack");
    send(8'h12, 1'b0, "ab2_d_ack");
    i2c_stop();
    push_rd(8'h40);
    i2c_start();
    send(8'hA0, 1'b0, "ab2_raddr_ack");
    send(8'h40, 1'b0, "ab2_rptr_ack");
    i2c_start();
    send(8'hA1, 1'b0, "ab2_rd_ack");
    tick(10);
    chk("ab2_drive_low", sda_w, 1'b0);
    rst_n = 1'b0;
    tick(1);
    chk("ab2_sda_released", sda_w, 1'b1);
    chk("ab2_rst_addr", regs.reg_addr, 8'h00);
    chk("ab2_rst_wdata", regs.reg_wdata, 8'h00);
    chk("ab2_rst_busy", busy, 1'b0);
    chk("ab2_rst_wr", regs.reg_wr, 1'b0);
    chk("ab2_rst_rd", regs.reg_rd, 1'b0);
    rst_n = 1'b1;
    tick(2);
    i2c_stop();
    push_wr(8'h50, 8'h77);
    i2c_start();
    send(8'hA0, 1'b0, "post_addr_ack");
    send(8'h50, 1'b0, "post_ptr_ack");
    send(8'h77, 1'b0, "post_d_ack");
    i2c_stop();
    chk("post_ptr_after", regs.reg_addr, 8'h51);

    // Sequential 4-byte read at the oversampling limit
    push_wr(8'h80, 8'hA5);
    push_wr(8'h81, 8'h00);
    push_wr(8'h82, 8'hFF);
    push_wr(8'h83, 8'h69);
    i2c_start();
    send(8'hA0, 1'b0, "seq_pre_addr_ack");
    send(8'h80, 1'b0, "seq_pre_ptr_ack");
    send(8'hA5, 1'b0, "seq_pre_d0_ack");
    send(8'h00, 1'b0, "seq_pre_d1_ack");
    send(8'hFF, 1'b0, "seq_pre_d2_ack");
    send(8'h69, 1'b0, "seq_pre_d3_ack");
    i2c_stop();
    push_rd(8'h80);
    push_rd(8'h81);
    push_rd(8'h82);
    push_rd(8'h83);
    i2c_start();
    send(8'hA0, 1'b0, "seq_addr_ack");
    send(8'h80, 1'b0, "seq_ptr_ack");
    i2c_start();
    send(8'hA1, 1'b0, "seq_rd_ack");
    recv(1'b0, 8'hA5, "seq_byte0");
    recv(1'b0, 8'h00, "seq_byte1");
    recv(1'b0, 8'hFF, "seq_byte2");
    recv(1'b1, 8'h69, "seq_byte3");
    chk("seq_idle_after_nack", busy, 1'b0);
    i2c_stop();

    tick(10);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
